alu_seq_core: RTL
=================

# alu_seq_core

Parametrised, handshaked successor to the 4-bit combinational ALU breadboard. Accepts an operand pair plus 4-bit opcode over a valid/ready interface and returns a 2·WIDTH-bit result with a 2-bit error code. ADD/SUB/logic complete in one cycle. MUL (shift-add) and DIV/MOD (restoring) are iterative, which fills the channels the combinational version left unconnected.

## Interface
- WIDTH, 4: operand width; legal range 2 to 16.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- A  in  WIDTH  operand A (dividend / multiplicand).
- B  in  WIDTH  operand B (divisor / multiplier).
- opcode  in  4  operation select, sampled on accept.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept; high only in IDLE.
- C  out  2·WIDTH  result, zero-extended unless stated otherwise.
- error  out  2  00 ok, 01 carry/borrow, 10 divide-by-zero, 11 illegal opcode.
- out_valid  out  1  C/error valid.
- out_ready  in  1  consumer accepts the result.

## Operation
- Opcodes:
  - 0001 ADD
  - 0010 SUB
  - 0011 MUL
  - 0100 DIV
  - 0101 MOD
  - 1001 AND
  - 1010 OR
  - 1011 XOR
  - All others are illegal.
- Accept: in_valid & in_ready at a rising edge. A, B and opcode are captured into internal registers. Input changes after accept have no effect.
- States: IDLE, MUL, DIV, DONE.
  - IDLE → DONE on accept of ADD/SUB/logic/illegal, or DIV/MOD with B==0.
  - IDLE → MUL on accept of MUL.
  - IDLE → DIV on accept of DIV/MOD with B≠0.
  - MUL/DIV → DONE after WIDTH iteration edges.
  - DONE → IDLE on out_valid & out_ready.
- ADD:
  - C = A+B, WIDTH+1 bits zero-extended.
  - error=01 when the carry out of bit WIDTH-1 is 1.
- SUB:
  - C low WIDTH bits = (A−B) mod 2^WIDTH; upper bits zero.
  - error=01 when A<B.
- MUL: C = A·B, full 2·WIDTH bits; error=00.
  - Each iteration conditionally adds the multiplicand to the partial product, then shifts.
- DIV/MOD: restoring division, one quotient bit per iteration.
  - DIV: C = quotient.
  - MOD: C = remainder.
  - B==0: C=0 and error=10, with no iterations.
- AND/OR/XOR: bitwise on WIDTH bits; error=00.
- Illegal opcode: C=0, error=11.
- out_valid = (state==DONE).
- C and error are registered and held stable in DONE until the output handshake completes.

## Timing
- Reset (rst low, asynchronous):
  - state=IDLE, C=0, error=00, out_valid=0, in_ready=1.
  - All internal iteration registers clear.
  - Any in-flight operation is discarded, including mid-MUL/DIV; no result is produced for it.
- Single-cycle ops (ADD/SUB/logic/illegal, DIV/MOD by zero): accepted at edge k, out_valid=1 from edge k+1.
- MUL/DIV/MOD: accepted at edge k, iterations on edges k+1 … k+WIDTH, out_valid=1 from edge k+WIDTH+1.
  - The iteration counter is $clog2(WIDTH+1) bits.
- Output handshake at edge m returns the block to IDLE, so in_ready=1 from edge m.
  - Minimum issue interval is 2 cycles (single-cycle op) or WIDTH+2 cycles (iterative op).
- in_ready is 0 in MUL, DIV and DONE. in_valid asserted there is ignored and not queued.
- out_ready held low stalls indefinitely in DONE with C/error unchanged.
- out_ready asserted while out_valid=0 has no effect.

## Structure
- Package alu_seq_pkg holds:
  - opcode localparams (OP_ADD … OP_XOR);
  - error-code localparams (ERR_OK, ERR_CARRY, ERR_DIV0, ERR_ILLEGAL);
  - the state enum.
- Sub-module alu_seq_divider: WIDTH-parameterised restoring divider step engine.
  - Driven by start/step from the core FSM.
  - Exposes quotient and remainder.
- The MUL datapath, logic ops and FSM stay in alu_seq_core. Expected total is 200–300 lines.

## Test plan
- ADD, WIDTH=4:
  - A=4, B=2 → C=0x06, error=00, out_valid one cycle after accept.
  - A=15, B=1 → C=0x10, error=01.
- SUB/logic, WIDTH=4:
  - SUB A=2, B=4 → C=0x0E, error=01.
  - AND A=1111, B=0010 → C=0x02.
  - Opcode 0000 → C=0, error=11.
- MUL, WIDTH=4: A=15, B=15 → C=0xE1 exactly 5 cycles after accept; in_ready=0 throughout.
- DIV/MOD, WIDTH=4:
  - DIV 13/4 → C=3.
  - MOD 13%4 → C=1.
  - DIV 7/0 → C=0, error=10, one-cycle latency.
  - Repeat with WIDTH=8: DIV 200/7 → C=28; MOD → C=4.
- Backpressure: hold out_ready low 6 cycles in DONE → C, error and out_valid stable; in_valid pulses during the stall are ignored.
- Reset mid-MUL: drop rst two cycles after accept → outputs zero immediately, in_ready=1 after release, next ADD 3+3 → C=6.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, error codes and FSM states for the sequential ALU
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_DIV = 4'b0100;
    localparam logic [3:0] OP_MOD = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b1001;
    localparam logic [3:0] OP_OR  = 4'b1010;
    localparam logic [3:0] OP_XOR = 4'b1011;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_CARRY   = 2'b01;
    localparam logic [1:0] ERR_DIV0    = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_seq_divider.sv
// rtl/alu_seq_divider.sv - restoring divider, one quotient bit per step
module alu_seq_divider
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    // r_quo starts as the dividend and shifts left, filling with quotient bits
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;

    // The partial remainder stays below the divisor, so the shifted value fits
    // in WIDTH+1 bits and the top bit of the trial difference is the borrow.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_div};
    assign w_fits  = ~w_trial[WIDTH];

    // Load operands on start, then one shift/trial-subtract/restore per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quo <= '0;
            r_rem <= '0;
            r_div <= '0;
        end else if (i_start) begin
            r_quo <= i_dividend;
            r_rem <= '0;
            r_div <= i_divisor;
        end else if (i_step) begin
            r_rem <= w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_fits};
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - handshaked ALU with iterative multiply and divide
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [3:0]         opcode,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*WIDTH-1:0] C,
    output logic [1:0]         error,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int CW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_op;
    logic [CW-1:0]    r_prod;
    logic [CW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_c;
    logic [1:0]       r_err;

    logic             w_accept;
    logic             w_is_div;
    logic             w_last;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [CW-1:0]    w_prod_nxt;
    logic [CW-1:0]    w_quick_c;
    logic [1:0]       w_quick_err;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    assign w_accept   = in_valid & in_ready;
    assign w_is_div   = (opcode == OP_DIV) || (opcode == OP_MOD);
    assign w_last     = (r_cnt == LAST_ITER);
    assign w_sum      = {1'b0, A} + {1'b0, B};
    assign w_diff     = A - B;
    assign w_prod_nxt = r_mplier[0] ? (r_prod + r_mcand) : r_prod;

    alu_seq_divider #(.WIDTH(WIDTH)) u_divider (
        .clk         (clk),
        .rst_n       (rst),
        .i_start     (w_accept & w_is_div),
        .i_step      (r_state == ST_DIV),
        .i_dividend  (A),
        .i_divisor   (B),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (opcode == OP_MUL)             w_state_nxt = ST_MUL;
                    else if (w_is_div && (B != '0))   w_state_nxt = ST_DIV;
                    else                              w_state_nxt = ST_DONE;
                end
            end
            ST_MUL, ST_DIV: if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Results that are known at accept time (also the divide-by-zero case)
    always_comb begin
        w_quick_c   = '0;
        w_quick_err = ERR_OK;
        case (opcode)
            OP_ADD: begin
                w_quick_c   = CW'(w_sum);
                w_quick_err = w_sum[WIDTH] ? ERR_CARRY : ERR_OK;
            end
            OP_SUB: begin
                w_quick_c   = CW'(w_diff);
                w_quick_err = (A < B) ? ERR_CARRY : ERR_OK;
            end
            OP_MUL:         w_quick_err = ERR_OK;
            OP_DIV, OP_MOD: w_quick_err = (B == '0) ? ERR_DIV0 : ERR_OK;
            OP_AND:         w_quick_c   = CW'(A & B);
            OP_OR:          w_quick_c   = CW'(A | B);
            OP_XOR:         w_quick_c   = CW'(A ^ B);
            default:        w_quick_err = ERR_ILLEGAL;
        endcase
    end

    // Operand capture and the shift-add multiplier iterations
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op     <= '0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_c      <= '0;
            r_err    <= ERR_OK;
        end else if (w_accept) begin
            r_op     <= opcode;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= CW'(A);
            r_mplier <= B;
            r_c      <= w_quick_c;
            r_err    <= w_quick_err;
        end else if (r_state == ST_MUL) begin
            r_prod   <= w_prod_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
        end else if (r_state == ST_DIV) begin
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    // Iterative results are taken straight from their registers, which are
    // frozen in DONE; everything else comes from the captured quick result.
    always_comb begin
        C = r_c;
        if ((r_state == ST_DONE) && (r_err == ERR_OK)) begin
            case (r_op)
                OP_MUL:  C = r_prod;
                OP_DIV:  C = CW'(w_quo);
                OP_MOD:  C = CW'(w_rem);
                default: C = r_c;
            endcase
        end
    end

    assign error = r_err;

endmodule
